// File: rtl/acia_sequencer.sv
// -----------------------------------------------------------------------------
// acia_sequencer
//
// Bus-master controller for a 6850-style ACIA register port. After reset it
// master-resets and configures the ACIA. It then polls the status register in
// a loop. Received bytes are drained into a valid/ready stream. The ACIA
// transmitter is shared between two byte-stream requesters with round-robin
// arbitration. A control-register rewrite can be requested at any time and
// takes precedence over RX/TX service.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   acia_cs/we/rs/din          ACIA register port strobe, direction, select, write data
//   acia_dout                  ACIA read data, valid the cycle after a read strobe
//   tx0_* / tx1_*              requester byte streams (valid/data in, 1-cycle ack out)
//   rx_valid/rx_data/rx_ready  received-byte stream towards the consumer
//   cfg_req/cfg_data/cfg_ack   control-register rewrite request
//   err_cnt                    saturating count of polls that reported rx_err (bit 4)
//   ready                      high once the init sequence has completed
// -----------------------------------------------------------------------------
module acia_sequencer #(
    parameter logic [7:0] CTRL_INIT = 8'h14,
    parameter int         ERRW      = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            acia_cs,
    output logic            acia_we,
    output logic            acia_rs,
    output logic [7:0]      acia_din,
    input  logic [7:0]      acia_dout,
    input  logic            tx0_valid,
    input  logic [7:0]      tx0_data,
    output logic            tx0_ack,
    input  logic            tx1_valid,
    input  logic [7:0]      tx1_data,
    output logic            tx1_ack,
    output logic            rx_valid,
    output logic [7:0]      rx_data,
    input  logic            rx_ready,
    input  logic            cfg_req,
    input  logic [7:0]      cfg_data,
    output logic            cfg_ack,
    output logic [ERRW-1:0] err_cnt,
    output logic            ready
);

    localparam logic [3:0] S_MRST   = 4'd0;
    localparam logic [3:0] S_CFG    = 4'd1;
    localparam logic [3:0] S_IDLE   = 4'd2;
    localparam logic [3:0] S_RCFG   = 4'd3;
    localparam logic [3:0] S_POLL   = 4'd4;
    localparam logic [3:0] S_PWAIT  = 4'd5;
    localparam logic [3:0] S_RXRD   = 4'd6;
    localparam logic [3:0] S_RXWAIT = 4'd7;
    localparam logic [3:0] S_TXWR   = 4'd8;
    localparam logic [3:0] S_TXGAP  = 4'd9;

    localparam logic [7:0]      ACIA_MRST = 8'h03;
    localparam logic [ERRW-1:0] ERR_ONE   = {{(ERRW-1){1'b0}}, 1'b1};

    logic [3:0]      state_q,    state_d;
    logic            armed_q,    armed_d;
    logic            ready_q,    ready_d;
    logic            rr_q,       rr_d;
    logic            grant_q,    grant_d;
    logic            both_q,     both_d;
    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q,  rx_data_d;
    logic [ERRW-1:0] err_cnt_q,  err_cnt_d;

    // The bus strobes are decoded from the state, so the reset state MRST
    // would drive a write while rst_n is still low. armed_q holds MRST off
    // for the first cycle after release, which keeps every output at 0 in reset.

    // NOTE: every signal assigned in this block gets a default at the top. A
    // path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d    = state_q;
        armed_d    = 1'b1;
        ready_d    = ready_q;
        rr_d       = rr_q;
        grant_d    = grant_q;
        both_d     = both_q;
        rx_valid_d = rx_valid_q & ~rx_ready;
        rx_data_d  = rx_data_q;
        err_cnt_d  = err_cnt_q;
        acia_cs    = 1'b0;
        acia_we    = 1'b0;
        acia_rs    = 1'b0;
        acia_din   = 8'h00;
        tx0_ack    = 1'b0;
        tx1_ack    = 1'b0;
        cfg_ack    = 1'b0;

        case (state_q)
            S_MRST: begin
                if (armed_q) begin
                    acia_cs  = 1'b1;
                    acia_we  = 1'b1;
                    acia_din = ACIA_MRST;
                    state_d  = S_CFG;
                end
            end
            S_CFG: begin
                acia_cs  = 1'b1;
                acia_we  = 1'b1;
                acia_din = CTRL_INIT;
                ready_d  = 1'b1;
                state_d  = S_IDLE;
            end
            S_IDLE: begin
                state_d = cfg_req ? S_RCFG : S_POLL;
            end
            S_RCFG: begin
                acia_cs  = 1'b1;
                acia_we  = 1'b1;
                acia_din = cfg_data;
                cfg_ack  = 1'b1;
                state_d  = S_IDLE;
            end
            S_POLL: begin
                acia_cs = 1'b1;
                state_d = S_PWAIT;
            end
            S_PWAIT: begin
                if (acia_dout[4] && (err_cnt_q != '1)) begin
                    err_cnt_d = err_cnt_q + ERR_ONE;
                end
                // A byte still held in rx_data blocks the ACIA read, so
                // consumer back-pressure shows up as an ACIA overrun.
                if (acia_dout[0] && !rx_valid_q) begin
                    state_d = S_RXRD;
                end else if (acia_dout[1] && (tx0_valid || tx1_valid)) begin
                    both_d  = tx0_valid & tx1_valid;
                    grant_d = (tx0_valid & tx1_valid) ? rr_q : tx1_valid;
                    state_d = S_TXWR;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RXRD: begin
                acia_cs = 1'b1;
                acia_rs = 1'b1;
                state_d = S_RXWAIT;
            end
            S_RXWAIT: begin
                rx_data_d  = acia_dout;
                rx_valid_d = 1'b1;
                state_d    = S_IDLE;
            end
            S_TXWR: begin
                acia_cs  = 1'b1;
                acia_we  = 1'b1;
                acia_rs  = 1'b1;
                acia_din = grant_q ? tx1_data : tx0_data;
                tx0_ack  = ~grant_q;
                tx1_ack  = grant_q;
                // The pointer only moves when there was real contention.
                if (both_q) begin
                    rr_d = ~grant_q;
                end
                state_d = S_TXGAP;
            end
            S_TXGAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_MRST;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so that every flop
    // samples the values from before this edge, whatever the block order is.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_MRST;
            armed_q    <= 1'b0;
            ready_q    <= 1'b0;
            rr_q       <= 1'b0;
            grant_q    <= 1'b0;
            both_q     <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= 8'h00;
            err_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            armed_q    <= armed_d;
            ready_q    <= ready_d;
            rr_q       <= rr_d;
            grant_q    <= grant_d;
            both_q     <= both_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign err_cnt  = err_cnt_q;
    assign ready    = ready_q;

endmodule

// File: tb/tb_acia_sequencer.sv
// -----------------------------------------------------------------------------
// tb_acia_sequencer
//
// Bench for acia_sequencer. A small ACIA register model answers the reads.
// Expected writes and expected RX bytes go into queues when the stimulus is
// issued. A monitor on the falling edge pops an entry and compares it each
// time the DUT writes the ACIA or hands over an RX byte.
// The stimulus drives inputs one time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_acia_sequencer;

    typedef struct {
        logic       rs;
        logic [7:0] din;
        logic       a0;
        logic       a1;
        logic       ca;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       acia_cs, acia_we, acia_rs;
    logic [7:0] acia_din;
    logic [7:0] acia_dout = 8'h00;
    logic       tx0_valid, tx1_valid, tx0_ack, tx1_ack;
    logic [7:0] tx0_data, tx1_data;
    logic       rx_valid, rx_ready;
    logic [7:0] rx_data;
    logic       cfg_req, cfg_ack;
    logic [7:0] cfg_data;
    logic [7:0] err_cnt;
    logic       ready;

    logic [7:0] status  = 8'h00;
    logic [7:0] rx_byte = 8'h00;

    wr_t        wr_q[$];
    logic [7:0] rx_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int poll_cnt = 0;
    int rd1_cnt  = 0;
    int tgt      = 0;

    acia_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .acia_cs   (acia_cs),
        .acia_we   (acia_we),
        .acia_rs   (acia_rs),
        .acia_din  (acia_din),
        .acia_dout (acia_dout),
        .tx0_valid (tx0_valid),
        .tx0_data  (tx0_data),
        .tx0_ack   (tx0_ack),
        .tx1_valid (tx1_valid),
        .tx1_data  (tx1_data),
        .tx1_ack   (tx1_ack),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .cfg_req   (cfg_req),
        .cfg_data  (cfg_data),
        .cfg_ack   (cfg_ack),
        .err_cnt   (err_cnt),
        .ready     (ready)
    );

    always #5 clk = ~clk;

    // ACIA register model: read data is registered on the read strobe.
    always @(posedge clk) begin
        if (acia_cs && !acia_we) begin
            acia_dout <= acia_rs ? rx_byte : status;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit cond(input int sel);
        case (sel)
            0:       return tx0_ack;
            1:       return tx1_ack;
            2:       return cfg_ack;
            3:       return rx_valid;
            4:       return (rx_q.size() == 0) && !rx_valid;
            5:       return rd1_cnt >= tgt;
            6:       return poll_cnt >= tgt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_for(input int sel, input int limit, input string name);
        bit hit = 1'b0;
        for (int i = 0; i < limit && !hit; i++) begin
            @(negedge clk);
            hit = cond(sel);
        end
        check({"wait_", name}, {31'd0, hit}, 32'd1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_wr(input logic rs, input logic [7:0] din,
                           input logic a0, input logic a1, input logic ca);
        wr_t e;
        e.rs = rs; e.din = din; e.a0 = a0; e.a1 = a1; e.ca = ca;
        wr_q.push_back(e);
    endtask

    // Monitor: compares every ACIA write and every RX handshake with the queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (acia_cs && acia_we) begin
                check("write_expected", {31'd0, wr_q.size() != 0}, 32'd1);
                if (wr_q.size() != 0) begin
                    wr_t e;
                    e = wr_q.pop_front();
                    check("write_rs_din_acks",
                          {20'd0, acia_rs, acia_din, tx0_ack, tx1_ack, cfg_ack},
                          {20'd0, e.rs, e.din, e.a0, e.a1, e.ca});
                end
            end else if (tx0_ack || tx1_ack || cfg_ack) begin
                check("ack_without_write", {29'd0, tx0_ack, tx1_ack, cfg_ack}, 32'd0);
            end
            if (acia_cs && !acia_we) begin
                if (acia_rs) rd1_cnt++;
                else         poll_cnt++;
            end
            if (rx_valid && rx_ready) begin
                check("rx_expected", {31'd0, rx_q.size() != 0}, 32'd1);
                if (rx_q.size() != 0) begin
                    logic [7:0] b;
                    b = rx_q.pop_front();
                    check("rx_data", {24'd0, rx_data}, {24'd0, b});
                end
            end
        end
    end

    initial begin
        int r0;
        int p0;

        rst_n     = 1'b0;
        tx0_valid = 1'b0; tx0_data = 8'h00;
        tx1_valid = 1'b0; tx1_data = 8'h00;
        rx_ready  = 1'b0;
        cfg_req   = 1'b0; cfg_data = 8'h00;

        // 1. Reset state, then master reset and CTRL_INIT writes back to back.
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {acia_cs, acia_we, acia_rs, acia_din, tx0_ack, tx1_ack, rx_valid,
               rx_data, cfg_ack, err_cnt, ready}, 32'd0);
        push_wr(1'b0, 8'h03, 1'b0, 1'b0, 1'b0);
        push_wr(1'b0, 8'h14, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        begin
            bit hit = 1'b0;
            for (int i = 0; i < 20 && !hit; i++) begin
                @(negedge clk);
                hit = acia_cs && acia_we;
            end
            check("wait_first_write", {31'd0, hit}, 32'd1);
        end
        @(negedge clk);
        check("cfg_write_consecutive", {21'd0, acia_cs, acia_we, acia_rs, acia_din},
              {21'd0, 3'b110, 8'h14});
        check("ready_low_during_cfg", {31'd0, ready}, 32'd0);
        @(negedge clk);
        check("ready_after_init", {31'd0, ready}, 32'd1);

        // 2. Single TX from requester 0, then the gap cycle before the next poll.
        step();
        tx0_data  = 8'h41;
        tx0_valid = 1'b1;
        push_wr(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
        status    = 8'h02;
        wait_for(0, 100, "tx0_single");
        @(negedge clk);
        check("txgap_no_strobe", {31'd0, acia_cs}, 32'd0);
        @(negedge clk);
        check("idle_no_strobe", {31'd0, acia_cs}, 32'd0);
        @(negedge clk);
        check("poll_after_gap", {29'd0, acia_cs, acia_we, acia_rs}, {29'd0, 3'b100});
        step();
        tx0_valid = 1'b0;
        status    = 8'h00;

        // 3. Both requesters busy: grants alternate starting with tx0.
        step();
        tx0_data = 8'hA0;
        tx1_data = 8'hB1;
        push_wr(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0);
        push_wr(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
        push_wr(1'b1, 8'hA0, 1'b1, 1'b0, 1'b0);
        push_wr(1'b1, 8'hB1, 1'b0, 1'b1, 1'b0);
        tx0_valid = 1'b1;
        tx1_valid = 1'b1;
        status    = 8'h02;
        for (int k = 0; k < 4; k++) begin
            wait_for(k % 2, 100, "rr_alternate");
        end
        step();
        tx0_valid = 1'b0;
        tx1_valid = 1'b0;
        status    = 8'h00;

        // 4. RX and TX both ready: RX read first, TX on the following poll.
        step();
        rx_ready  = 1'b0;
        rx_byte   = 8'h5A;
        rx_q.push_back(8'h5A);
        tx1_data  = 8'hC3;
        tx1_valid = 1'b1;
        push_wr(1'b1, 8'hC3, 1'b0, 1'b1, 1'b0);
        status    = 8'h03;
        wait_for(1, 100, "tx1_after_rx");
        check("rx_before_tx", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h5A});
        step();
        tx1_valid = 1'b0;
        status    = 8'h00;
        rx_ready  = 1'b1;
        wait_for(4, 100, "rx_drain_5a");

        // 5. RX hold-off while the consumer stalls, then resume.
        step();
        rx_ready = 1'b0;
        rx_byte  = 8'h11;
        rx_q.push_back(8'h11);
        status   = 8'h01;
        wait_for(3, 100, "rx_11_valid");
        r0 = rd1_cnt;
        repeat (40) @(negedge clk);
        check("holdoff_no_reads", rd1_cnt, r0);
        check("holdoff_data_kept", {23'd0, rx_valid, rx_data}, {23'd0, 1'b1, 8'h11});
        step();
        rx_byte  = 8'h22;
        rx_q.push_back(8'h22);
        tgt      = r0 + 1;
        rx_ready = 1'b1;
        wait_for(5, 100, "read_after_release");
        step();
        status = 8'h00;
        wait_for(4, 100, "rx_drain_22");
        check("rx_reads_total", rd1_cnt, r0 + 1);

        // 6. Reconfiguration, then the error counter runs into saturation.
        step();
        cfg_data = 8'h95;
        push_wr(1'b0, 8'h95, 1'b0, 1'b0, 1'b1);
        cfg_req  = 1'b1;
        wait_for(2, 100, "cfg_ack");
        step();
        cfg_req = 1'b0;
        check("err_cnt_zero", {24'd0, err_cnt}, 32'd0);
        step();
        status = 8'h10;
        p0     = poll_cnt;
        tgt    = p0 + 100;
        wait_for(6, 1000, "polls_100");
        step();
        @(posedge clk);
        #1;
        check("err_cnt_100", {24'd0, err_cnt}, 32'd100);
        tgt = p0 + 300;
        wait_for(6, 2000, "polls_300");
        step();
        @(posedge clk);
        #1;
        check("err_cnt_saturated", {24'd0, err_cnt}, 32'd255);
        status = 8'h00;
        check("ready_sticky", {31'd0, ready}, 32'd1);

        repeat (5) @(negedge clk);
        check("wr_queue_drained", wr_q.size(), 32'd0);
        check("rx_queue_drained", rx_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
